// File: rtl/lcd_frame_scheduler_if.sv
// Line contents, redraw request and LCD byte-writer handshake bundled between
// the character converters, the frame scheduler and the byte writer.
interface lcd_frame_scheduler_if;
    localparam int unsigned LINE_W = 144;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned IDX_W  = 6;

    logic [LINE_W-1:0] iLine1;
    logic [LINE_W-1:0] iLine2;
    logic              iRefresh;
    logic [DATA_W-1:0] oWrData;
    logic              oWrRS;
    logic              oWrStart;
    logic              iWrDone;
    logic              oBusy;
    logic              oFrameDone;
    logic [IDX_W-1:0]  oIndex;

    modport master (
        input  iLine1, iLine2, iRefresh, iWrDone,
        output oWrData, oWrRS, oWrStart, oBusy, oFrameDone, oIndex
    );

    modport slave (
        output iLine1, iLine2, iRefresh, iWrDone,
        input  oWrData, oWrRS, oWrStart, oBusy, oFrameDone, oIndex
    );
endinterface

// File: rtl/lcd_frame_scheduler.sv
// Walks the 38-entry LCD frame (init commands, line 1, line change, line 2)
// through the byte-writer handshake, drawing from snapshots taken at frame start.
module lcd_frame_scheduler #(
    parameter int unsigned DLY_CYCLES   = 262143,
    parameter bit          AUTO_REFRESH = 1'b1
) (
    input  logic                  iCLK,
    input  logic                  iRST,
    lcd_frame_scheduler_if.master bus
);
    localparam int unsigned CHAR_W     = 9;
    localparam int unsigned NCHARS     = 16;
    localparam int unsigned LINE_W     = CHAR_W * NCHARS;
    localparam int unsigned DATA_W     = 8;
    localparam int unsigned IDX_W      = 6;
    localparam int unsigned LAST_IDX   = 37;
    localparam int unsigned RESUME_IDX = 4;
    localparam int unsigned LINE1_BASE = 5;
    localparam int unsigned LINE2_CMD  = 21;
    localparam int unsigned LINE2_BASE = 22;
    localparam int unsigned CNT_W      = (DLY_CYCLES > 1) ? $clog2(DLY_CYCLES) : 1;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DELAY, NEXT} state_t;

    state_t              state;
    logic [LINE_W-1:0]   snap1;
    logic [LINE_W-1:0]   snap2;
    logic [CNT_W-1:0]    cnt;
    logic [IDX_W-1:0]    idx;
    logic [DATA_W-1:0]   wr_data;
    logic                wr_rs;
    logic                wr_start;
    logic                busy;
    logic                frame_done;
    logic                armed;
    logic                init_pending;
    logic                refresh_pending;

    logic                changed_c;
    logic                start_c;
    logic [CHAR_W-1:0]   entry_c;

    // Character pos of a packed line; char 0 sits in the top bits.
    function automatic logic [CHAR_W-1:0] char_at(input logic [LINE_W-1:0] line,
                                                  input logic [31:0]       pos);
        return line[(LINE_W - 1) - pos * CHAR_W -: CHAR_W];
    endfunction

    // Frame table lookup for the current index.
    always_comb begin
        entry_c = '0;
        if (idx < IDX_W'(LINE1_BASE)) begin
            case (idx)
                6'd0:    entry_c = 9'h038;
                6'd1:    entry_c = 9'h00C;
                6'd2:    entry_c = 9'h001;
                6'd3:    entry_c = 9'h006;
                default: entry_c = 9'h080;
            endcase
        end else if (idx < IDX_W'(LINE2_CMD)) begin
            entry_c = char_at(snap1, 32'(idx - IDX_W'(LINE1_BASE)));
        end else if (idx == IDX_W'(LINE2_CMD)) begin
            entry_c = 9'h0C0;
        end else if (idx <= IDX_W'(LAST_IDX)) begin
            entry_c = char_at(snap2, 32'(idx - IDX_W'(LINE2_BASE)));
        end
    end

    always_comb begin
        changed_c = AUTO_REFRESH && ({bus.iLine1, bus.iLine2} != {snap1, snap2});
        start_c   = init_pending || refresh_pending || bus.iRefresh || changed_c;
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state           <= IDLE;
            snap1           <= '0;
            snap2           <= '0;
            cnt             <= '0;
            idx             <= '0;
            wr_data         <= '0;
            wr_rs           <= 1'b0;
            wr_start        <= 1'b0;
            busy            <= 1'b0;
            frame_done      <= 1'b0;
            armed           <= 1'b0;
            init_pending    <= 1'b1;
            refresh_pending <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            busy       <= (state != IDLE);
            // Requests seen mid-frame coalesce into one pending redraw.
            if (bus.iRefresh || (changed_c && (state != IDLE))) begin
                refresh_pending <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (start_c) begin
                        snap1           <= bus.iLine1;
                        snap2           <= bus.iLine2;
                        refresh_pending <= 1'b0;
                        idx             <= init_pending ? '0 : IDX_W'(RESUME_IDX);
                        state           <= ISSUE;
                    end
                end
                ISSUE: begin
                    wr_rs    <= entry_c[CHAR_W-1];
                    wr_data  <= entry_c[DATA_W-1:0];
                    wr_start <= 1'b1;
                    armed    <= 1'b0;
                    state    <= WAIT;
                end
                WAIT: begin
                    // Done must be seen low first so the previous write's done is ignored.
                    if (!bus.iWrDone) begin
                        armed <= 1'b1;
                    end
                    if (armed && bus.iWrDone) begin
                        wr_start <= 1'b0;
                        cnt      <= '0;
                        state    <= DELAY;
                    end
                end
                DELAY: begin
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(DLY_CYCLES - 1)) begin
                        state <= NEXT;
                    end
                end
                NEXT: begin
                    if (idx == IDX_W'(LAST_IDX)) begin
                        frame_done   <= 1'b1;
                        init_pending <= 1'b0;
                        state        <= IDLE;
                    end else begin
                        idx   <= idx + IDX_W'(1);
                        state <= ISSUE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.oWrData    = wr_data;
    assign bus.oWrRS      = wr_rs;
    assign bus.oWrStart   = wr_start;
    assign bus.oBusy      = busy;
    assign bus.oFrameDone = frame_done;
    assign bus.oIndex     = idx;
endmodule

// File: tb/tb_lcd_frame_scheduler.sv
// Bench for lcd_frame_scheduler: writer model plus a frame-level reference of
// the expected byte stream ({index, RS, data}) under directed and random lines.
module tb_lcd_frame_scheduler;
    localparam int unsigned DLY = 4;

    logic clk = 1'b0;
    logic rst;
    logic wr_done = 1'b1;
    always #5 clk = ~clk;

    lcd_frame_scheduler_if bus ();
    assign bus.iWrDone = wr_done;

    lcd_frame_scheduler #(.DLY_CYCLES(DLY), .AUTO_REFRESH(1'b1)) dut (
        .iCLK(clk),
        .iRST(rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    logic [14:0] got_q[$];
    logic [14:0] exp_q[$];
    int rise_q[$];
    int fd_q[$];
    int busy_fall_cyc = -1;
    int proto_bad = 0;
    int wtimer = -1;
    logic start_q = 1'b0;
    logic busy_q = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Writer model and monitor: done drops one cycle after start rises, returns 3 later.
    always @(negedge clk) begin
        if (!rst && start_q && !bus.oWrStart && (wtimer >= 0 || !wr_done)) proto_bad++;
        if (!rst && bus.oWrStart && !start_q) begin
            got_q.push_back({bus.oIndex, bus.oWrRS, bus.oWrData});
            rise_q.push_back(cyc);
            wtimer = 0;
        end else if (wtimer >= 0) begin
            wtimer++;
            if (wtimer == 1) wr_done = 1'b0;
            else if (wtimer == 4) begin
                wr_done = 1'b1;
                wtimer  = -1;
            end
        end
        if (!rst && bus.oFrameDone) fd_q.push_back(cyc);
        if (!rst && busy_q && !bus.oBusy) busy_fall_cyc = cyc;
        start_q = bus.oWrStart;
        busy_q  = bus.oBusy;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [8:0] ch(input logic [143:0] line, input int c);
        logic [143:0] t;
        t = line >> (9 * (15 - c));
        return t[8:0];
    endfunction

    function automatic logic [8:0] init_cmd(input int i);
        case (i)
            0: return 9'h038;
            1: return 9'h00C;
            2: return 9'h001;
            3: return 9'h006;
            default: return 9'h080;
        endcase
    endfunction

    // Reference: the byte stream a frame starting at 'from' must produce.
    task automatic expect_frame(input logic [143:0] l1, input logic [143:0] l2, input int from);
        for (int i = from; i < 5; i++) exp_q.push_back({6'(i), init_cmd(i)});
        for (int c = 0; c < 16; c++) exp_q.push_back({6'(5 + c), ch(l1, c)});
        exp_q.push_back({6'd21, 9'h0C0});
        for (int c = 0; c < 16; c++) exp_q.push_back({6'(22 + c), ch(l2, c)});
    endtask

    task automatic check_writes(input string tag, input int gb);
        chk({tag, "_nwrites"}, 64'(got_q.size() - gb), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (gb + i < got_q.size())
                chk($sformatf("%s_write%0d", tag, i), 64'(got_q[gb + i]), 64'(exp_q[i]));
        end
        exp_q.delete();
    endtask

    task automatic wait_frames(input string tag, input int target, input int budget);
        int k = 0;
        while (fd_q.size() < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_frame_timeout"}, 64'(fd_q.size() >= target), 64'(1));
    endtask

    task automatic wait_issue(input int target);
        int k = 0;
        while (!(bus.oIndex == 6'(target) && bus.oWrStart) && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chk($sformatf("reach_idx%0d", target), 64'(bus.oIndex), 64'(target));
        k = 0;
        while (bus.oWrStart && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("start_drop", 64'(bus.oWrStart), 64'(0));
    endtask

    task automatic pulse_refresh();
        bus.iRefresh = 1'b1;
        @(negedge clk);
        bus.iRefresh = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_data"}, 64'(bus.oWrData), 64'(0));
        chk({tag, "_rs"}, 64'(bus.oWrRS), 64'(0));
        chk({tag, "_start"}, 64'(bus.oWrStart), 64'(0));
        chk({tag, "_busy"}, 64'(bus.oBusy), 64'(0));
        chk({tag, "_fdone"}, 64'(bus.oFrameDone), 64'(0));
        chk({tag, "_index"}, 64'(bus.oIndex), 64'(0));
    endtask

    function automatic logic [143:0] hexline();
        logic [143:0] l = '0;
        logic [7:0] v;
        for (int c = 0; c < 16; c++) begin
            v = (c < 10) ? 8'(8'h30 + c) : 8'(8'h41 + c - 10);
            l = (l << 9) | 144'({1'b1, v});
        end
        return l;
    endfunction

    function automatic logic [143:0] randline();
        logic [143:0] l = '0;
        for (int c = 0; c < 16; c++) l = (l << 9) | 144'({1'b1, 8'($urandom_range(126, 32))});
        return l;
    endfunction

    logic [143:0] l1, l2, l2n;
    int gb, fb, req, lat;

    initial begin
        rst          = 1'b1;
        bus.iLine1   = '0;
        bus.iLine2   = '0;
        bus.iRefresh = 1'b0;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");

        // Power-up frame with "0".."F" on both rows.
        l1 = hexline();
        l2 = hexline();
        bus.iLine1 = l1;
        bus.iLine2 = l2;
        gb = got_q.size();
        fb = fd_q.size();
        rst = 1'b0;
        expect_frame(l1, l2, 0);
        wait_frames("init", fb + 1, 2000);
        repeat (30) @(negedge clk);
        check_writes("init", gb);
        chk("init_one_fdone", 64'(fd_q.size() - fb), 64'(1));
        if (fd_q.size() > fb) chk("init_busy_fall", 64'(busy_fall_cyc - fd_q[fb]), 64'(1));
        chk("init_idle_busy", 64'(bus.oBusy), 64'(0));

        // Explicit redraw from idle.
        gb = got_q.size();
        fb = fd_q.size();
        req = cyc;
        pulse_refresh();
        expect_frame(l1, l2, 4);
        wait_frames("refresh", fb + 1, 2000);
        repeat (30) @(negedge clk);
        lat = (rise_q.size() > gb) ? rise_q[gb] - req : -1;
        chk("refresh_latency", 64'(lat), 64'(2));
        check_writes("refresh", gb);

        // Random content changes while idle start a frame on their own.
        for (int it = 0; it < 3; it++) begin
            l1 = randline();
            l2 = randline();
            gb = got_q.size();
            fb = fd_q.size();
            req = cyc;
            bus.iLine1 = l1;
            bus.iLine2 = l2;
            expect_frame(l1, l2, 4);
            wait_frames($sformatf("rand%0d", it), fb + 1, 2000);
            repeat (30) @(negedge clk);
            lat = (rise_q.size() > gb) ? rise_q[gb] - req : -1;
            chk($sformatf("rand%0d_latency", it), 64'(lat), 64'(2));
            check_writes($sformatf("rand%0d", it), gb);
        end

        // Line 2 char 3 changes mid-frame: old frame completes, one more follows.
        gb = got_q.size();
        fb = fd_q.size();
        pulse_refresh();
        wait_issue(10);
        l2n = l2 ^ (144'(1) << (9 * (15 - 3)));
        bus.iLine2 = l2n;
        expect_frame(l1, l2, 4);
        expect_frame(l1, l2n, 4);
        wait_frames("midchg", fb + 2, 4000);
        repeat (100) @(negedge clk);
        chk("midchg_frames", 64'(fd_q.size() - fb), 64'(2));
        check_writes("midchg", gb);
        l2 = l2n;

        // Refresh coincident with the final NEXT, then three coalesced requests.
        gb = got_q.size();
        fb = fd_q.size();
        pulse_refresh();
        wait_issue(37);
        repeat (DLY) @(negedge clk);
        req = cyc;
        pulse_refresh();
        for (int p = 0; p < 3; p++) begin
            repeat ($urandom_range(40, 5)) @(negedge clk);
            pulse_refresh();
        end
        expect_frame(l1, l2, 4);
        expect_frame(l1, l2, 4);
        expect_frame(l1, l2, 4);
        wait_frames("coinc", fb + 3, 6000);
        repeat (100) @(negedge clk);
        chk("coinc_frames", 64'(fd_q.size() - fb), 64'(3));
        if (fd_q.size() > fb) chk("coinc_fdone_cycle", 64'(fd_q[fb] - req), 64'(1));
        if (fd_q.size() > fb && rise_q.size() > gb + 34)
            chk("coinc_restart_gap", 64'(rise_q[gb + 34] - fd_q[fb]), 64'(2));
        check_writes("coinc", gb);

        // Reset while in DELAY at index 20, then a full frame from index 0.
        pulse_refresh();
        wait_issue(20);
        rst = 1'b1;
        @(negedge clk);
        check_outputs_zero("rst_mid");
        repeat (2) @(negedge clk);
        gb = got_q.size();
        fb = fd_q.size();
        rst = 1'b0;
        expect_frame(l1, l2, 0);
        wait_frames("postrst", fb + 1, 2000);
        repeat (30) @(negedge clk);
        check_writes("postrst", gb);
        chk("postrst_fdone", 64'(fd_q.size() - fb), 64'(1));

        chk("writer_protocol", 64'(proto_bad), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
